// File: rtl/cpu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared definitions for the single-cycle CPU control path:
//               branch condition codes, run/halt state encoding, flag
//               positions and the branch-offset helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Branch condition codes evaluated against the {Z,S,C,V} flags
    localparam logic [2:0] COND_EQ  = 3'b000;
    localparam logic [2:0] COND_NE  = 3'b001;
    localparam logic [2:0] COND_LT  = 3'b010;
    localparam logic [2:0] COND_GE  = 3'b011;
    localparam logic [2:0] COND_LTU = 3'b100;
    localparam logic [2:0] COND_GEU = 3'b101;
    localparam logic [2:0] COND_AL  = 3'b110;
    localparam logic [2:0] COND_NV  = 3'b111;

    // Run/halt control state, explicitly one bit wide
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    // Bit positions inside the 4-bit flag vector {Z,S,C,V}
    localparam int FLAG_Z = 3;
    localparam int FLAG_S = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Signed word offset converted to a 32-bit byte offset
    function automatic logic [31:0] word_off_to_bytes(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/cond_eval.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cond_eval
// Description : Purely combinational branch-condition evaluator. Maps a
//               3-bit condition code and the {Z,S,C,V} flags to cond_true.
// Revision    : 1.0 - initial release
// ============================================================================
module cond_eval
    import cpu_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [3:0] flags,
    output logic       cond_true
);

    logic w_z;
    logic w_s;
    logic w_c;
    logic w_v;

    assign w_z = flags[FLAG_Z];
    assign w_s = flags[FLAG_S];
    assign w_c = flags[FLAG_C];
    assign w_v = flags[FLAG_V];

    // Decode the condition code; carry is "no borrow" for subtract-style compares
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            COND_EQ:  cond_true = w_z;
            COND_NE:  cond_true = !w_z;
            COND_LT:  cond_true = w_s ^ w_v;
            COND_GE:  cond_true = !(w_s ^ w_v);
            COND_LTU: cond_true = !w_c;
            COND_GEU: cond_true = w_c;
            COND_AL:  cond_true = 1'b1;
            COND_NV:  cond_true = 1'b0;
            default:  cond_true = 1'b0;
        endcase
    end

endmodule : cond_eval
`default_nettype wire

// File: rtl/branch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : branch_unit
// Description : Program-counter owner for the single-cycle CPU. Latches ALU
//               flags, evaluates branch conditions (with same-cycle flag
//               forwarding), selects sequential/branch/jump next PC, provides
//               a RUN/HALT control state and a saturating taken counter.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flag_we,
    input  logic             zeroflag,
    input  logic             signflag,
    input  logic             carryflag,
    input  logic             overflowflag,
    input  logic             branch_en,
    input  logic [2:0]       cond,
    input  logic [15:0]      imm16,
    input  logic             jump,
    input  logic [25:0]      jaddr,
    input  logic             stall,
    input  logic             halt_req,
    input  logic             resume,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic [3:0]       flags_q,
    output logic             taken,
    output logic             halted,
    output logic [CNT_W-1:0] taken_cnt
);

    // Architectural state
    logic [31:0]      pc_q;
    logic [31:0]      pc_d;
    logic [3:0]       flags_d;
    state_e           state_q;
    state_e           state_d;
    logic             halted_q;
    logic             halted_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Datapath intermediates
    logic [3:0]       w_alu_flags;
    logic [3:0]       w_eff_flags;
    logic             w_cond_true;
    logic             w_is_run;
    logic             w_advance;
    logic [31:0]      w_br_target;
    logic [31:0]      w_j_target;

    assign w_alu_flags = {zeroflag, signflag, carryflag, overflowflag};

    // A flag-setting instruction that is also a branch sees its own flags
    assign w_eff_flags = flag_we ? w_alu_flags : flags_q;

    cond_eval u_cond_eval (
        .cond      (cond),
        .flags     (w_eff_flags),
        .cond_true (w_cond_true)
    );

    assign w_is_run    = (state_q == ST_RUN);
    // The instruction at pc retires only when running, unstalled and not halting
    assign w_advance   = w_is_run && !stall && !halt_req;

    assign pc_plus4    = pc_q + 32'd4;
    assign w_br_target = pc_plus4 + word_off_to_bytes(imm16);
    assign w_j_target  = {pc_plus4[31:28], jaddr, 2'b00};

    assign taken       = w_advance && (jump || (branch_en && w_cond_true));

    assign pc          = pc_q;
    assign halted      = halted_q;
    assign taken_cnt   = cnt_q;

    // Next-state logic: PC select, flag latch, run/halt transitions, counter
    always_comb begin
        pc_d    = pc_q;
        flags_d = flags_q;
        state_d = state_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_RUN: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (resume && !halt_req) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (w_advance) begin
            if (jump) begin
                pc_d = w_j_target;
            end else if (branch_en && w_cond_true) begin
                pc_d = w_br_target;
            end else begin
                pc_d = pc_plus4;
            end
        end

        if (w_is_run && !stall && flag_we) begin
            flags_d = w_alu_flags;
        end

        if (taken && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        halted_d = (state_d == ST_HALT);
    end

    // All state registers share one asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            flags_q  <= 4'b0000;
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            pc_q     <= pc_d;
            flags_q  <= flags_d;
            state_q  <= state_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule : branch_unit
`default_nettype wire

// File: doc/branch_unit.md
Name: branch_unit

Overview:
- Consumes the ALU status flags (zeroflag, signflag, carryflag, overflowflag) and owns the program counter of the single-cycle CPU.
- Latches flags from flag-setting instructions and evaluates branch conditions against them.
- Selects the next PC from sequential, conditional-branch, or jump sources.
- Provides a RUN/HALT state machine and a saturating taken-branch counter for debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of the taken-branch counter.

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- rst_n  in  1  asynchronous active-low reset
- flag_we  in  1  current instruction writes the flag register
- zeroflag  in  1  ALU zero flag
- signflag  in  1  ALU sign flag
- carryflag  in  1  ALU carry flag (carry-out of in_a + ~in_b + 1 for subtract)
- overflowflag  in  1  ALU signed overflow flag
- branch_en  in  1  current instruction is a conditional branch
- cond  in  3  branch condition code
- imm16  in  16  signed word offset of the branch
- jump  in  1  current instruction is an absolute jump
- jaddr  in  26  word address of the jump
- stall  in  1  hold PC and all state this cycle
- halt_req  in  1  enter HALT
- resume  in  1  leave HALT
- pc  out  32  current PC
- pc_plus4  out  32  pc + 4, combinational
- flags_q  out  4  registered flags {Z,S,C,V}
- taken  out  1  combinational; branch or jump is taken this cycle
- halted  out  1  FSM is in HALT
- taken_cnt  out  CNT_W  saturating count of taken branches and jumps

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, flags_q=4'b0000, FSM=RUN, taken_cnt=0, halted=0. taken follows its combinational definition using the reset state.
- Flag register: on a clock edge with flag_we=1, stall=0, and state RUN, flags_q <= {zeroflag, signflag, carryflag, overflowflag}. Otherwise flags_q holds.
- Effective flags: if flag_we=1 in the same cycle as branch_en, the live ALU flags are forwarded. Otherwise flags_q is used.
- Condition codes on effective flags {Z,S,C,V}:
  - 000 EQ: Z
  - 001 NE: !Z
  - 010 LT: S^V
  - 011 GE: !(S^V)
  - 100 LTU: !C
  - 101 GEU: C
  - 110 AL: 1
  - 111 NV: 0
- Targets, with 32-bit wrap-around and no trap:
  - branch: pc_plus4 + (sign_extend(imm16) << 2)
  - jump: {pc_plus4[31:28], jaddr, 2'b00}
- taken = RUN && !stall && !halt_req && (jump || (branch_en && cond_true)).
- Next-PC priority, highest first: halt_req > jump > branch_en&&cond_true > sequential. If jump and branch_en are both 1, jump wins.
- FSM:
  - RUN -> HALT when halt_req=1. halt_req overrides stall. On that edge the PC is held, so the instruction at pc is not retired.
  - RUN with stall=1: pc, flags_q, and taken_cnt are held.
  - RUN otherwise: pc <= next PC.
  - HALT: pc, flags_q, and taken_cnt are frozen. halted=1.
  - HALT -> RUN when resume=1 and halt_req=0. Execution restarts at the held pc on the following cycle.
  - In HALT, halt_req=1 and resume=1 together: stay in HALT.
- taken_cnt increments by 1 on each edge where taken=1. It saturates at all-ones and never wraps.
- Latency: PC updates one edge after the decision. The flag-to-branch path has zero cycles of latency through the forwarding path.
- Reset asserted mid-operation clears all state immediately, independent of clk.

Decomposition:
- Shared package cpu_pkg holds:
  - condition-code localparams: COND_EQ, COND_NE, COND_LT, COND_GE, COND_LTU, COND_GEU, COND_AL, COND_NV
  - FSM state encoding: ST_RUN=1'b0, ST_HALT=1'b1
  - flag index constants: FLAG_Z=3, FLAG_S=2, FLAG_C=1, FLAG_V=0
- One sub-module, cond_eval: purely combinational, maps cond plus 4 flags to cond_true. The ALU testbench can reuse it later.

Test Plan:
- Reset and sequential: release rst_n, hold all controls low for 3 cycles -> pc = 0x0, 0x4, 0x8, 0xC; flags_q=0; taken_cnt=0.
- Forwarded branch: at pc=0x10, drive flag_we=1, zeroflag=1, branch_en=1, cond=EQ, imm16=16'hFFFC -> taken=1, next pc=0x04, flags_q=4'b1000, taken_cnt=1.
- Registered-flag branch, signed vs unsigned: load flags S=1, V=0, C=0. Next cycle at pc=0x20 with cond=LT, imm16=2 -> pc=0x2C. Repeat with cond=GEU -> not taken, pc=pc+4.
- Priority: jump=1, jaddr=26'h000_0040, and branch_en=1 with cond=AL, both at pc=0x3000_0000 -> next pc=0x3000_0100. Same cycle with stall=1 -> pc held, taken=0, taken_cnt unchanged.
- Halt/resume: halt_req pulse at pc=0x50 -> halted=1, and pc stays 0x50 for 5 cycles even with jump=1. resume=1 -> halted=0, then pc=0x54 on the next edge. Assert rst_n=0 while halted -> pc=RESET_PC and halted=0 immediately.
- Saturation and wrap: with CNT_W=2, issue 5 AL branches -> taken_cnt reaches 3 and holds. Branch with imm16=1 at pc=0xFFFF_FFF8 -> pc=0x0000_0000.
